// File: rtl/mem_port_arbiter_if.sv
// Purpose: fetch, data and memory-side signals of the unified memory port arbiter.
// Latency: none; this is wiring only. The master modport is the arbiter's view and slave is the environment's view.
// Backpressure: the fetch and data requests are held until their gnt; memory commands are held until mem_ready.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  if_req, if_addr, if_flush,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        output if_req, if_addr, if_flush,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between the fetch and data requesters, with anti-starvation under MEM_ARB_ANTISTARVE_EN.
// Latency: the grant is issued in the same cycle as the request. A read takes at least 3 cycles and a store takes at least 2.
// Backpressure: mem_ready stalls the command in ISSUE. Requesters hold their req until gnt, and no grant is given while busy.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.master   bus,
    output logic                 busy
);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

    state_t state, state_nxt;
    cmd_t   cmd, cmd_nxt;
    logic   owner_dm, owner_dm_nxt;
    logic   flushed, flushed_nxt;
    logic   grant_if, grant_dm, starve_force;

`ifdef MEM_ARB_ANTISTARVE_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] starve_cnt;

    assign starve_force = (starve_cnt == CNT_W'(STARVE_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_dm && bus.if_req && !starve_force) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    // STARVE_MAX only matters when the anti-starvation counter is built.
    logic unused_starve_max;
    assign unused_starve_max = ^STARVE_MAX;
    assign starve_force = 1'b0;
`endif

    // Grants are masked while reset is held, so outputs stay quiet even when requests are pending.
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (state == IDLE && rst_n) begin
            if (bus.if_req && (!bus.dm_req || starve_force)) begin
                grant_if = 1'b1;
            end else if (bus.dm_req) begin
                grant_dm = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        cmd_nxt        = cmd;
        owner_dm_nxt   = owner_dm;
        bus.if_gnt     = grant_if;
        bus.dm_gnt     = grant_dm;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.if_rvalid  = 1'b0;
        bus.if_rdata   = '0;
        bus.dm_rvalid  = 1'b0;
        bus.dm_rdata   = '0;
        case (state)
            IDLE: begin
                if (grant_dm) begin
                    cmd_nxt      = '{we: bus.dm_we, addr: bus.dm_addr, wdata: bus.dm_wdata};
                    owner_dm_nxt = 1'b1;
                    state_nxt    = ISSUE;
                end else if (grant_if) begin
                    cmd_nxt      = '{we: 1'b0, addr: bus.if_addr, wdata: '0};
                    owner_dm_nxt = 1'b0;
                    state_nxt    = ISSUE;
                end
            end
            ISSUE: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = cmd.we;
                bus.mem_addr  = cmd.addr;
                bus.mem_wdata = cmd.wdata;
                if (bus.mem_ready) begin
                    // Stores get no memory response, so they are acknowledged on the handshake itself.
                    if (cmd.we) begin
                        bus.dm_rvalid = 1'b1;
                        state_nxt     = IDLE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    if (owner_dm) begin
                        bus.dm_rvalid = 1'b1;
                        bus.dm_rdata  = bus.mem_rdata;
                    end else if (!(flushed || bus.if_flush)) begin
                        bus.if_rvalid = 1'b1;
                        bus.if_rdata  = bus.mem_rdata;
                    end
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign flushed_nxt = (state_nxt != IDLE) &&
                         (flushed || (state != IDLE && !owner_dm && bus.if_flush));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cmd      <= '0;
            owner_dm <= 1'b0;
            flushed  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cmd      <= cmd_nxt;
            owner_dm <= owner_dm_nxt;
            flushed  <= flushed_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the IF stage (instruction fetch) and the MEM stage (load/store issued under memRead/memWrite from the control decode).
- Arbitrates between the two, sequences each transaction through issue and response phases, and routes the response back to the owner.
- Drops fetch responses killed by a taken-branch flush.
- Sits between the pipeline stage registers and the memory model/controller.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive fetch losses before fetch is forced to win (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_flush  in  1  kill in-flight fetch response (taken branch/jump).
- if_gnt  out  1  fetch accepted (one-cycle pulse).
- if_rvalid  out  1  fetch data valid (one-cycle pulse).
- if_rdata  out  DATA_W  fetch data.
- dm_req  in  1  data request; held until dm_gnt.
- dm_we  in  1  1=store, 0=load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_gnt  out  1  data accepted (one-cycle pulse).
- dm_rvalid  out  1  load data valid, or store-complete ack (one-cycle pulse).
- dm_rdata  out  DATA_W  load data; 0 on store ack.
- mem_req  out  1  memory command valid.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ready  in  1  memory accepts command this cycle (mem_req && mem_ready = handshake).
- mem_rvalid  in  1  read data returned; never asserted for writes.
- mem_rdata  in  DATA_W  read data.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: asynchronous assert of rst_n=0 forces state IDLE and clears owner, flushed flag, latched command and starve count.
  - All outputs are 0 during reset and in IDLE with no request.
  - An outstanding memory transaction is abandoned; a later stray mem_rvalid in IDLE is ignored.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If dm_req=1, grant data (dm_gnt=1, combinational, same cycle).
  - Else if if_req=1, grant fetch.
  - The winner's addr/we/wdata and owner are registered; next state is ISSUE.
  - Only one gnt is asserted per cycle; the loser keeps its req held.
- ISSUE:
  - mem_req=1 with the latched command; stay in ISSUE until mem_ready=1.
  - On handshake with a store: dm_rvalid=1 that same cycle, dm_rdata=0, next state IDLE.
  - On handshake with a read: next state WAIT.
- WAIT:
  - mem_req=0; wait for mem_rvalid.
  - When mem_rvalid=1, route mem_rdata to the owner's rdata with the owner's rvalid=1 that cycle (combinational pass-through); next state IDLE.
  - The non-owner's rvalid is always 0.
- Latency (zero-wait memory): req in cycle 0 (IDLE, gnt) -> mem_req cycle 1 -> earliest rvalid cycle 2 -> IDLE cycle 3, where it can re-grant. Minimum 3 cycles per read, 2 per store.
- Flush:
  - if_flush=1 while owner=fetch in ISSUE or WAIT sets the flushed flag. The transaction still completes at memory, but if_rvalid is suppressed.
  - if_flush in the same cycle as mem_rvalid also suppresses if_rvalid.
  - if_flush has no effect in IDLE, or when owner=data.
  - The flag clears on return to IDLE.
- Simultaneous requests: without the optional feature, data always wins.
- A request raised in ISSUE/WAIT is not granted until IDLE.
- Addresses are passed through unmodified; no alignment checks.

Optional Feature:
- MEM_ARB_ANTISTARVE_EN defined:
  - A starve counter, saturating at STARVE_MAX, increments each IDLE grant to data while if_req=1.
  - It resets to 0 on any fetch grant.
  - When the count equals STARVE_MAX and both requests are present, fetch wins.
- MEM_ARB_ANTISTARVE_EN undefined: no counter exists; strict data priority.

Test Plan:
- Fetch alone: if_req=1, if_addr=0x100, mem_ready=1, mem_rvalid at cycle 2 with rdata=0x00500093 -> if_gnt at cycle 0, mem_req/mem_addr=0x100 at cycle 1, if_rvalid=1 with if_rdata=0x00500093 at cycle 2, busy=0 at cycle 3.
- Contention: if_req and dm_req (load, 0x2000) both at cycle 0 -> dm_gnt at cycle 0, if_gnt=0. The fetch is granted in the IDLE cycle after the load's dm_rvalid.
- Store with back-pressure: dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF, mem_ready low for 3 cycles -> mem_req held with stable addr/data for 4 cycles; dm_rvalid=1 with dm_rdata=0 on the handshake cycle; no WAIT state.
- Flush: fetch owner in WAIT, if_flush=1 one cycle before mem_rvalid -> if_rvalid stays 0, arbiter returns to IDLE. Repeat with the flush on the same cycle as mem_rvalid -> if_rvalid stays 0.
- Reset mid-op: rst_n low during WAIT -> outputs 0 immediately (asynchronous). After release, a mem_rvalid pulse produces no rvalid on either port; the next request is granted normally.
- With MEM_ARB_ANTISTARVE_EN and STARVE_MAX=4: both requests continuously asserted -> 4 data grants, then 1 fetch grant, repeating. Without the macro: data grants only.
